// File: rtl/full_adder_if.sv
// full_adder_if: operand/result bundle for the registered ripple-carry adder.
//   a, b      operands (unsigned, WIDTH bits)
//   cin       carry into bit 0
//   in_valid  qualifies a/b/cin this cycle
//   sum       (a + b + cin) mod 2^WIDTH
//   cout      carry out of bit WIDTH-1
//   out_valid qualifies sum/cout
// master drives operands and receives results; slave is the adder side.
interface full_adder_if #(
    parameter int unsigned WIDTH = 1
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             in_valid;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             out_valid;

    modport master (
        output a, b, cin, in_valid,
        input  sum, cout, out_valid
    );

    modport slave (
        input  a, b, cin, in_valid,
        output sum, cout, out_valid
    );
endinterface

// File: rtl/full_adder.sv
// full_adder: ripple-carry adder built from a chain of per-bit full-adder cells,
// with an optional output register stage.
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  full_adder_if slave: a/b/cin/in_valid in, sum/cout/out_valid out
// REGISTER_OUT != 0: sum/cout/out_valid registered, 1-cycle latency, one op per cycle.
// REGISTER_OUT == 0: sum/cout combinational; out_valid = in_valid & ~rst.
module full_adder #(
    parameter int unsigned WIDTH        = 1,
    parameter int unsigned REGISTER_OUT = 1
) (
    input logic         clk,
    input logic         rst,
    full_adder_if.slave bus
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = bus.cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign s[i]   = bus.a[i] ^ bus.b[i] ^ c[i];
        assign c[i+1] = (bus.a[i] & bus.b[i]) | (bus.a[i] & c[i]) | (bus.b[i] & c[i]);
    end

    if (REGISTER_OUT != 0) begin : g_reg
        logic [WIDTH-1:0] sum_q;
        logic             cout_q;
        logic             out_valid_q;

        // sum/cout load every cycle; out_valid alone marks meaningful results.
        always_ff @(posedge clk) begin
            if (rst) begin
                sum_q       <= '0;
                cout_q      <= 1'b0;
                out_valid_q <= 1'b0;
            end else begin
                sum_q       <= s;
                cout_q      <= c[WIDTH];
                out_valid_q <= bus.in_valid;
            end
        end

        assign bus.sum       = sum_q;
        assign bus.cout      = cout_q;
        assign bus.out_valid = out_valid_q;
    end else begin : g_comb
        // clk has no role without the register stage.
        logic unused_clk;
        assign unused_clk = clk;

        assign bus.sum       = s;
        assign bus.cout      = c[WIDTH];
        assign bus.out_valid = bus.in_valid & ~rst;
    end
endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: three adder configurations (1-bit registered, 8-bit registered,
// 4-bit combinational) driven with directed and random operands. A reference model
// based on plain integer addition checks every cycle; literal expectations pin it.
module tb_full_adder;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    bit   started = 1'b0;

    full_adder_if #(.WIDTH(1)) if1 ();
    full_adder_if #(.WIDTH(8)) if8 ();
    full_adder_if #(.WIDTH(4)) if4 ();

    full_adder #(.WIDTH(1), .REGISTER_OUT(1)) u_w1 (.clk(clk), .rst(rst), .bus(if1));
    full_adder #(.WIDTH(8), .REGISTER_OUT(1)) u_w8 (.clk(clk), .rst(rst), .bus(if8));
    full_adder #(.WIDTH(4), .REGISTER_OUT(0)) u_w4 (.clk(clk), .rst(rst), .bus(if4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [64:0] add_ref(input longint unsigned a, input longint unsigned b,
                                            input bit cin);
        logic [64:0] r;
        r = {1'b0, a} + {1'b0, b} + 65'(cin);
        return r;
    endfunction

    // Reference model and per-cycle compare.
    always begin : compare
        logic [64:0] r1, r8, r4;
        logic        v1, v8;
        @(posedge clk);
        if (rst) begin
            r1 = '0; r8 = '0; v1 = 1'b0; v8 = 1'b0;
            started = 1'b1;
        end else begin
            r1 = add_ref(64'(if1.a), 64'(if1.b), if1.cin);
            r8 = add_ref(64'(if8.a), 64'(if8.b), if8.cin);
            v1 = if1.in_valid;
            v8 = if8.in_valid;
        end
        #1;
        if (started) begin
            chk("w1 sum/cout", {if1.cout, if1.sum}, r1[1:0]);
            chk("w1 out_valid", if1.out_valid, v1);
            chk("w8 sum/cout", {if8.cout, if8.sum}, r8[8:0]);
            chk("w8 out_valid", if8.out_valid, v8);
        end
        #3;
        r4 = add_ref(64'(if4.a), 64'(if4.b), if4.cin);
        chk("w4 comb sum/cout", {if4.cout, if4.sum}, r4[4:0]);
        chk("w4 comb out_valid", if4.out_valid, if4.in_valid & ~rst);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [1:0] exp_tbl [8];
        logic [7:0] a8_tbl [3];
        logic [7:0] b8_tbl [3];
        logic       c8_tbl [3];
        logic [8:0] e8_tbl [3];
        exp_tbl = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        a8_tbl  = '{8'hFF, 8'hFF, 8'h12};
        b8_tbl  = '{8'h01, 8'hFF, 8'h34};
        c8_tbl  = '{1'b0, 1'b1, 1'b1};
        e8_tbl  = '{9'h100, 9'h1FF, 9'h047};

        rst = 1'b1;
        if1.a = 1'b1; if1.b = 1'b1; if1.cin = 1'b1; if1.in_valid = 1'b1;
        if8.a = '0;   if8.b = '0;   if8.cin = 1'b0; if8.in_valid = 1'b0;
        if4.a = 4'h9; if4.b = 4'h7; if4.cin = 1'b0; if4.in_valid = 1'b1;

        // Combinational config answers before any clock edge.
        #1;
        chk("lit w4 9+7", {if4.cout, if4.sum}, 5'b1_0000);
        chk("lit w4 valid in reset", if4.out_valid, 1'b0);

        // Reset held for two edges wins over valid input.
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("lit reset w1 sum/cout", {if1.cout, if1.sum}, 2'b00);
            chk("lit reset w1 valid", if1.out_valid, 1'b0);
        end
        rst = 1'b0;
        #1;
        chk("lit w4 valid after reset", if4.out_valid, 1'b1);
        tick();
        chk("lit post-reset w1 sum/cout", {if1.cout, if1.sum}, 2'b11);
        chk("lit post-reset w1 valid", if1.out_valid, 1'b1);

        // Exhaustive 1-bit table; 8-bit directed cases alongside.
        for (int i = 0; i < 8; i++) begin
            {if1.a, if1.b, if1.cin} = 3'(i);
            if1.in_valid = 1'b1;
            if (i < 3) begin
                if8.a = a8_tbl[i]; if8.b = b8_tbl[i]; if8.cin = c8_tbl[i];
                if8.in_valid = 1'b1;
            end
            tick();
            chk("lit w1 table", {if1.cout, if1.sum}, exp_tbl[i]);
            chk("lit w1 table valid", if1.out_valid, 1'b1);
            if (i < 3) chk("lit w8 directed", {if8.cout, if8.sum}, e8_tbl[i]);
        end

        // in_valid gaps reproduced one cycle later.
        for (int i = 0; i < 6; i++) begin
            if1.in_valid = (i % 2 == 0);
            tick();
            chk("lit gap pattern", if1.out_valid, (i % 2 == 0));
        end

        // Reset mid-stream: input at a reset edge is dropped, the next one goes through.
        if1.a = 1'b1; if1.b = 1'b0; if1.cin = 1'b0; if1.in_valid = 1'b1;
        rst = 1'b1;
        tick();
        chk("lit midstream dropped", if1.out_valid, 1'b0);
        rst = 1'b0;
        if1.a = 1'b0; if1.b = 1'b1; if1.cin = 1'b1;
        tick();
        chk("lit midstream next", {if1.out_valid, if1.cout, if1.sum}, 3'b110);

        // Random traffic checked by the model every cycle.
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 19) == 0);
            if1.a = 1'($urandom); if1.b = 1'($urandom); if1.cin = 1'($urandom);
            if1.in_valid = 1'($urandom);
            if8.a = 8'($urandom); if8.b = 8'($urandom); if8.cin = 1'($urandom);
            if8.in_valid = 1'($urandom);
            if4.a = 4'($urandom); if4.b = 4'($urandom); if4.cin = 1'($urandom);
            if4.in_valid = 1'($urandom);
            tick();
        end
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Registered ripple-carry adder, built from a chain of per-bit full-adder cells.
- Default configuration (WIDTH=1) is a classic 1-bit full adder: SUM = A^B^CIN, COUT = majority(A,B,CIN).
- Used as the leaf arithmetic primitive for wider datapaths. It has one clock domain and an optional output register stage, so it can sit in pipelined paths.

Parameters:
- WIDTH, 1, operand width in bits (legal range 1..64).
- REGISTER_OUT, 1, 1 = SUM/COUT/OUT_VALID registered (1-cycle latency); 0 = purely combinational outputs (clk/rst affect only OUT_VALID gating, see Behaviour).

Ports:
- clk  input  1  Rising-edge clock.
- rst  input  1  Synchronous, active-high reset.
- A  input  WIDTH  Operand A, unsigned.
- B  input  WIDTH  Operand B, unsigned.
- CIN  input  1  Carry in to bit 0.
- IN_VALID  input  1  Qualifies A/B/CIN this cycle.
- SUM  output  WIDTH  (A + B + CIN) mod 2^WIDTH.
- COUT  output  1  Carry out of bit WIDTH-1.
- OUT_VALID  output  1  Qualifies SUM/COUT.

Behaviour:
- Per-bit cell i:
  - s[i] = A[i] ^ B[i] ^ c[i]
  - c[i+1] = (A[i]&B[i]) | (A[i]&c[i]) | (B[i]&c[i])
  - c[0] = CIN; COUT = c[WIDTH].
- Arithmetic: {COUT,SUM} = A + B + CIN exactly, with WIDTH+1-bit result and no truncation. Maximum (all-ones + all-ones + 1) gives COUT=1, SUM=all-ones.
- REGISTER_OUT=1:
  - On each rising clk edge with rst=0: SUM <= s, COUT <= c[WIDTH], OUT_VALID <= IN_VALID.
  - Latency is exactly 1 cycle. Throughput is one operation per cycle and back-to-back inputs are allowed.
  - SUM/COUT are loaded every cycle regardless of IN_VALID. OUT_VALID alone marks meaningful results.
- REGISTER_OUT=0:
  - SUM/COUT follow inputs combinationally with zero latency.
  - OUT_VALID = IN_VALID & ~rst, combinational.
- Reset (synchronous, active-high):
  - Sampled on the rising clk edge. While rst=1 at an edge: SUM <= 0, COUT <= 0, OUT_VALID <= 0.
  - Reset wins over simultaneous IN_VALID=1; that input is discarded.
  - Reset mid-stream: the result in flight is lost. The first post-reset OUT_VALID corresponds to the first IN_VALID sampled with rst=0.
- There is no asynchronous behaviour on rst. Outputs before the first clock edge are undefined until reset is applied.
- No backpressure: the downstream must accept every OUT_VALID cycle.
- X-free: no latches. All registered outputs are driven from a single always block on posedge clk.

Test Plan:
- WIDTH=1, REGISTER_OUT=1, exhaustive 8 combinations of A/B/CIN with IN_VALID=1 each cycle -> one cycle later {COUT,SUM} = 00,01,01,10,01,10,10,11 in order (000->00, 001->01, 010->01, 011->10, 100->01, 101->10, 110->10, 111->11), OUT_VALID=1.
- Reset: drive A=1,B=1,CIN=1,IN_VALID=1 with rst=1 for 2 edges -> SUM=0, COUT=0, OUT_VALID=0. Release rst -> next edge gives SUM=1, COUT=1, OUT_VALID=1.
- WIDTH=8: A=8'hFF, B=8'h01, CIN=0 -> SUM=8'h00, COUT=1. Then A=8'hFF, B=8'hFF, CIN=1 -> SUM=8'hFF, COUT=1. Then A=8'h12, B=8'h34, CIN=1 -> SUM=8'h47, COUT=0.
- IN_VALID gaps: alternate IN_VALID 1/0 over 6 cycles -> OUT_VALID reproduces the same pattern delayed by exactly 1 cycle.
- Reset mid-stream: assert rst for one edge between two valid inputs -> the first result is suppressed (OUT_VALID=0 that cycle), the second appears normally.
- REGISTER_OUT=0, WIDTH=4: A=4'h9, B=4'h7, CIN=0 -> SUM=4'h0, COUT=1 within the same cycle, no clock needed.
